// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames (start, 8 data bits LSB first, stop) with a ready/valid byte interface.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits (8E1).
module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      shift, shift_n;
    logic            tx_n;
    logic            bit_end;
`ifdef UART_TX_PARITY_EN
    logic            par, par_n;
`endif

    // State register; tx is registered from the next-state view so it changes on the same edge as the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            tx    <= tx_n;
`ifdef UART_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    assign bit_end = (cnt == LAST);

    // Next-state and datapath: the baud counter only runs outside IDLE and wraps at every bit boundary
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (valid) begin
                    state_n = START;
                    shift_n = data;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^data;
`endif
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        shift_n = {1'b0, shift[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE) begin
            cnt_n = bit_end ? '0 : cnt + CW'(1);
        end
    end

    // Outputs: handshake from the current state, serial line value from the state being entered
    always_comb begin
        ready = (state == IDLE);
        busy  = ~ready;
        tx_n  = 1'b1;
        case (state_n)
            IDLE:    tx_n = 1'b1;
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            STOP:    tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
    end

endmodule
